// File: rtl/fifo_pkg.sv
// Shared sizing constants and pointer/count width helper for the synchronous FIFO.
package fifo_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int ASIZE_DEF = 2;

    // Pointers and count carry one extra bit so that DEPTH itself is representable.
    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DSIZE array, synchronous write, asynchronous read, no reset.
module sync_fifo_mem #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    logic [DSIZE-1:0] mem_q [2**ASIZE];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered rdata.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AFULL_TH  = 3,
    parameter int AEMPTY_TH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DSIZE-1:0]   wdata,
    input  logic               w_en,
    input  logic               r_en,
    output logic [DSIZE-1:0]   rdata,
    output logic               wfull,
    output logic               rempty,
    output logic               walmost_full,
    output logic               ralmost_empty,
    output logic [ASIZE:0]     count,
    output logic               overflow,
    output logic               underflow
);

    localparam int PW = ptr_width(ASIZE);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_TH);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             wfull_q, wfull_d;
    logic             rempty_q, rempty_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic [DSIZE-1:0] mem_rdata;

    assign wr_acc = w_en & ~wfull_q;
    assign rd_acc = r_en & ~rempty_q;

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[ASIZE-1:0]),
        .wdata_i (wdata),
        .raddr_i (rptr_q[ASIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + PW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - PW'(1);
        end
        wfull_d  = (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]) && (wptr_d[ASIZE] != rptr_d[ASIZE]);
        rempty_d = (wptr_d == rptr_d);
        afull_d  = (count_d >= AFULL_C);
        aempty_d = (count_d <= AEMPTY_C);
        ovf_d    = ovf_q | (w_en & wfull_q);
        // A read that coincides with a write on an empty FIFO is deferred, not an error.
        udf_d    = udf_q | (r_en & rempty_q & ~w_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = rempty_q ? '0 : mem_rdata;
`else
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) begin
            rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

    assign wfull         = wfull_q;
    assign rempty        = rempty_q;
    assign walmost_full  = afull_q;
    assign ralmost_empty = aempty_q;
    assign count         = count_q;
    assign overflow      = ovf_q;
    assign underflow     = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DSIZE=16, ASIZE=2, AFULL_TH=3, AEMPTY_TH=1, registered rdata).
module tb_sync_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] wdata;
    logic        w_en;
    logic        r_en;
    logic [15:0] rdata;
    logic        wfull;
    logic        rempty;
    logic        walmost_full;
    logic        ralmost_empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;

    sync_fifo #(
        .DSIZE     (16),
        .ASIZE     (2),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wdata         (wdata),
        .w_en          (w_en),
        .r_en          (r_en),
        .rdata         (rdata),
        .wfull         (wfull),
        .rempty        (rempty),
        .walmost_full  (walmost_full),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_tests;
    int unsigned n_fail;

    logic [15:0] sb[$];
    int          m_count;
    logic        m_ovf;
    logic        m_udf;
    logic [15:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(m_count));
        check({tag, ".wfull"}, 32'(wfull), 32'(m_count == 4));
        check({tag, ".rempty"}, 32'(rempty), 32'(m_count == 0));
        check({tag, ".afull"}, 32'(walmost_full), 32'(m_count >= 3));
        check({tag, ".aempty"}, 32'(ralmost_empty), 32'(m_count <= 1));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        check({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = '0;
    endtask

    // One clock cycle of stimulus; inputs are applied and sampled 1 time unit after the edge.
    task automatic cycle(input string tag, input logic w, input logic r, input logic [15:0] d);
        logic wacc, racc;
        w_en  = w;
        r_en  = r;
        wdata = d;
        wacc = w && (m_count != 4);
        racc = r && (m_count != 0);
        if (w && m_count == 4) m_ovf = 1'b1;
        if (r && m_count == 0 && !w) m_udf = 1'b1;
        if (wacc) sb.push_back(d);
        if (racc) m_rdata = sb.pop_front();
        m_count = m_count + int'(wacc) - int'(racc);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check_all(tag);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst   = 1'b1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Fill to full, then overflow attempt
        cycle("fill1", 1'b1, 1'b0, 16'h1111);
        cycle("fill2", 1'b1, 1'b0, 16'h2222);
        cycle("fill3", 1'b1, 1'b0, 16'h3333);
        cycle("fill4", 1'b1, 1'b0, 16'h4444);
        cycle("ovf",   1'b1, 1'b0, 16'h5555);

        // Drain, then underflow attempt
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 1'b1, 16'h0000);
        cycle("udf", 1'b0, 1'b1, 16'h0000);

        // Simultaneous requests at count 2, 4 and 0
        apply_reset();
        cycle("sim_pre", 1'b1, 1'b0, 16'hA001);
        cycle("sim_pre", 1'b1, 1'b0, 16'hA002);
        cycle("sim_c2",  1'b1, 1'b1, 16'hA003);
        cycle("sim_pre", 1'b1, 1'b0, 16'hA004);
        cycle("sim_pre", 1'b1, 1'b0, 16'hA005);
        cycle("sim_c4",  1'b1, 1'b1, 16'hDEAD);
        for (int i = 0; i < 3; i++) cycle("sim_drain", 1'b0, 1'b1, 16'h0000);
        cycle("sim_c0",  1'b1, 1'b1, 16'hB00B);
        cycle("sim_post", 1'b0, 1'b1, 16'h0000);

        // Interleaved pairs across several pointer wraps
        for (int i = 0; i < 10; i++) begin
            cycle("wrap_w", 1'b1, 1'b0, 16'(16'h0100 + i));
            cycle("wrap_r", 1'b0, 1'b1, 16'h0000);
        end
        for (int i = 0; i < 5; i++) cycle("wrap_fill", 1'b1, 1'b0, 16'(16'h0200 + i));
        for (int i = 0; i < 4; i++) cycle("wrap_drain", 1'b0, 1'b1, 16'h0000);

        // Async reset mid-burst at count 3 with overflow set
        apply_reset();
        for (int i = 0; i < 5; i++) cycle("mid_fill", 1'b1, 1'b0, 16'(16'h0300 + i));
        cycle("mid_rd", 1'b0, 1'b1, 16'h0000);
        check("mid_pre_count", 32'(count), 32'd3);
        check("mid_pre_ovf", 32'(overflow), 32'd1);
        apply_reset();
        cycle("post_rst_w", 1'b1, 1'b0, 16'h7777);
        cycle("post_rst_r", 1'b0, 1'b1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
